// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered status flags and 1-cycle read latency.
// Optional sticky overflow/underflow flags are built only when PARAM_FIFO_ERR_FLAGS_EN is defined.
module param_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wren,
    input  logic                     rden,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C        = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C        = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic [DATA_WIDTH-1:0] o_data_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge
    assign wr_acc_s = wren && (!full_r || rden);
    assign rd_acc_s = rden && !empty_r;

    // Next occupancy from the accepted write/read pair
    always_comb begin
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointers, occupancy, read data and status flags derived from next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            count_r        <= {CW{1'b0}};
            o_data_r       <= {DATA_WIDTH{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                o_data_r <= mem_r[rd_ptr_r];
            end
            count_r        <= count_next_s;
            full_r         <= (count_next_s == DEPTH_C);
            empty_r        <= (count_next_s == {CW{1'b0}});
            almost_full_r  <= (count_next_s >= AF_C);
            almost_empty_r <= (count_next_s <= AE_C);
        end
    end

    assign o_data       = o_data_r;
    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;
    logic ovf_set_s;
    logic unf_set_s;

    assign ovf_set_s = wren && full_r && !rden;
    assign unf_set_s = rden && empty_r;

    // Sticky error flags; a same-cycle error event wins over clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s || (overflow_r && !clr_err);
            underflow_r <= unf_set_s || (underflow_r && !clr_err);
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    logic unused_clr_err_s;

    assign unused_clr_err_s = clr_err;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus random traffic against a queue model.
module tb_param_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wren;
    logic          rden;
    logic [DW-1:0] i_data;
    logic          clr_err;
    logic [DW-1:0] o_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_odata;
    logic          m_ovf;
    logic          m_unf;

    param_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .rden(rden), .i_data(i_data),
        .clr_err(clr_err), .o_data(o_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_odata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int sz = q.size();
        chk({tag, ".count"},        32'(count),        32'(sz));
        chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
        chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({tag, ".o_data"},       32'(o_data),       32'(m_odata));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
        chk({tag, ".count_le_depth"}, 32'(count <= 4'd8), 32'd1);
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue and all outputs are checked
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                         input logic c, input string tag);
        int sz = q.size();
        bit wa = w && ((sz < DEPTH) || r);
        bit ra = r && (sz > 0);
        wren = w; rden = r; i_data = d; clr_err = c;
        if (ERR_EN) begin
            m_ovf = (w && sz == DEPTH && !r) || (m_ovf && !c);
            m_unf = (r && sz == 0) || (m_unf && !c);
        end
        @(posedge clk);
        #1;
        if (ra) m_odata = q.pop_front();
        if (wa) q.push_back(d);
        check_all(tag);
        wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0; i_data = '0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one write too many
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, DW'(i), 1'b0, "fill");
            if (i == 5) chk("af_before_6", 32'(almost_full), 32'd0);
            if (i == 6) chk("af_at_6", 32'(almost_full), 32'd1);
        end
        chk("full_at_8", 32'(full), 32'd1);
        chk("count_at_8", 32'(count), 32'd8);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0, "overfill");
        chk("overfill_count", 32'(count), 32'd8);
        chk("overfill_flag", 32'(overflow), 32'(ERR_EN));

        // Drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, "drain");
            chk("drain_order", 32'(o_data), 32'(i));
        end
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_ae", 32'(almost_empty), 32'd1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, "underread");
        chk("underread_hold", 32'(o_data), 32'h08);
        chk("underread_flag", 32'(underflow), 32'(ERR_EN));

        // Error event in the clear cycle keeps the flag; a plain clear drops both
        cycle(1'b0, 1'b1, 8'h00, 1'b1, "clr_vs_set");
        chk("clr_vs_set_unf", 32'(underflow), 32'(ERR_EN));
        chk("clr_vs_set_ovf", 32'(overflow), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "clr");
        chk("clr_unf", 32'(underflow), 32'd0);

        // Simultaneous read/write while full
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0, "refill");
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, "full_rw");
        chk("full_rw_data", 32'(o_data), 32'h01);
        chk("full_rw_count", 32'(count), 32'd8);
        chk("full_rw_full", 32'(full), 32'd1);
        for (int i = 2; i <= 9; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, "full_rw_drain");
            chk("full_rw_drain_val", 32'(o_data), (i == 9) ? 32'hAA : 32'(i));
        end

        // Simultaneous read/write while empty: no bypass
        cycle(1'b1, 1'b1, 8'h55, 1'b0, "empty_rw");
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_empty", 32'(empty), 32'd0);
        chk("empty_rw_hold", 32'(o_data), 32'hAA);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, "empty_rw_read");
        chk("empty_rw_read_val", 32'(o_data), 32'h55);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "clr2");

        // Interleaved write/read pairs wrapping the pointers twice
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, DW'($urandom), 1'b0, "pair_wr");
            cycle(1'b0, 1'b1, 8'h00, 1'b0, "pair_rd");
        end

        // Random traffic with shifting write/read bias and occasional clears
        for (int ph = 0; ph < 4; ph++) begin
            int wp = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 120; i++) begin
                cycle(logic'($urandom_range(0, 99) < wp),
                      logic'($urandom_range(0, 99) < (100 - wp)),
                      DW'($urandom),
                      logic'($urandom_range(0, 19) == 0),
                      "random");
            end
        end

        // Asynchronous reset mid-operation at count 5
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, "pre_rst_drain");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h30 + i), 1'b0, "pre_rst_fill");
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_o_data", 32'(o_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 8'h00, 1'b0, "post_rst_rd");
        chk("post_rst_unf", 32'(underflow), 32'(ERR_EN));
        chk("post_rst_o_data", 32'(o_data), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 Parameter AF_THRESH, default DEPTH-2, count at or above which almost_full asserts; 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 1, count at or below which almost_empty asserts; 0..DEPTH-1.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wren  input  1  write request.
REQ-008 rden  input  1  read request.
REQ-009 i_data  input  DATA_WIDTH  write data.
REQ-010 clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 o_data  output  DATA_WIDTH  registered read data.
REQ-012 full  output  1  registered, count == DEPTH.
REQ-013 empty  output  1  registered, count == 0.
REQ-014 almost_full  output  1  registered, count >= AF_THRESH.
REQ-015 almost_empty  output  1  registered, count <= AE_THRESH.
REQ-016 count  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky, write attempted while full and not accepted.
REQ-018 underflow  output  1  sticky, read attempted while empty.

Function
REQ-019 Write SHALL be accepted when wren && (!full || rden); accepted write stores i_data at wr_ptr and increments wr_ptr modulo DEPTH.
REQ-020 Read SHALL be accepted when rden && !empty; accepted read loads o_data with entry at rd_ptr on the same edge (1-cycle latency) and increments rd_ptr modulo DEPTH.
REQ-021 o_data SHALL hold its previous value on any cycle without an accepted read.
REQ-022 Full with wren && rden: both accepted, count unchanged, o_data gets oldest entry, new data written into freed slot.
REQ-023 Empty with wren && rden: write accepted, read rejected, no bypass; count becomes 1, o_data unchanged, underflow sets.
REQ-024 count_next SHALL be count + accepted_write - accepted_read; full, empty, almost_full, almost_empty SHALL be registered functions of count_next, updating on the same edge as count.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or lost entry.
REQ-026 overflow SHALL set on wren && full && !rden; underflow SHALL set on rden && empty; both remain set until clr_err or reset.
REQ-027 clr_err has priority below a same-cycle set: a new error event in the clr_err cycle leaves the flag set.
REQ-028 Entry contents SHALL not be reset; only pointers, count, flags and o_data are reset.

Reset
REQ-029 On rst_n low, immediately: wr_ptr=0, rd_ptr=0, count=0, o_data=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-030 Reset asserted mid-operation SHALL discard all contents; first read after deassertion is rejected until a write occurs.

Configuration
REQ-031 Macro PARAM_FIFO_ERR_FLAGS_EN: when defined, overflow/underflow/clr_err behave per REQ-026/027.
REQ-032 Without PARAM_FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied to 0, clr_err ignored, no flag registers synthesised; all other behaviour identical.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1)
REQ-033 Write 0x01..0x08 -> full=1 after 8th edge, almost_full=1 after 6th, count=8; extra wren -> count stays 8, overflow=1 (macro on) or 0 (macro off).
REQ-034 Then read 8 times -> o_data 0x01..0x08 in order, one per edge; empty=1 and almost_empty=1 after last read; 9th rden -> o_data stays 0x08, underflow=1.
REQ-035 Full, wren=rden=1 with i_data=0xAA -> o_data=0x01, count=8, full=1; subsequent drain returns 0x02..0x08 then 0xAA.
REQ-036 Empty, wren=rden=1 with i_data=0x55 -> count=1, empty=0, o_data unchanged; next rden -> o_data=0x55.
REQ-037 20 interleaved write/read pairs crossing pointer wrap twice -> output sequence equals input sequence, count never exceeds 8.
REQ-038 Assert rst_n low at count=5 -> all outputs at REQ-029 values before next clk edge; rden after release -> underflow=1, o_data=0.
